// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/shift/add/compare ops plus
// iterative unsigned multiply (shift-add) and divide (restoring), WIDTH steps each.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] portOut,
  output logic [WIDTH-1:0] portHi,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  // Handshake: an op transfers on a rising edge where in_valid && in_ready; a result
  // transfers on a rising edge where out_valid && out_ready. Neither valid waits on ready.

  localparam logic [3:0] OP_SLL   = 4'd0;
  localparam logic [3:0] OP_SRL   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             accept;
  logic             last_step;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_rsv;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;

  assign state_dbg = state;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !RST;
        if (in_valid && !RST) begin
          if (aluop == OP_MULTU)     state_nxt = MUL;
          else if (aluop == OP_DIVU) state_nxt = DIV;
          else                       state_nxt = DONE;
        end
      end
      MUL, DIV: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign add_res = portA + portB;
  assign sub_res = portA - portB;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_rsv = 1'b0;
    case (aluop)
      OP_SLL:  sc_res = portA << portB[SHW-1:0];
      OP_SRL:  sc_res = portA >> portB[SHW-1:0];
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) && (add_res[WIDTH-1] != portA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) && (sub_res[WIDTH-1] != portA[WIDTH-1]);
      end
      OP_AND:  sc_res = portA & portB;
      OP_OR:   sc_res = portA | portB;
      OP_XOR:  sc_res = portA ^ portB;
      OP_NOR:  sc_res = ~(portA | portB);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
      OP_MULTU, OP_DIVU: sc_res = '0;
      // Reserved codes finish as a single-cycle op with every output cleared.
      default: sc_rsv = 1'b1;
    endcase
  end

  // Multiply: acc_hi accumulates, acc_lo starts as the multiplier and fills with
  // product bits shifted out of the accumulator, so {acc_hi, acc_lo} ends as A*B.
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and the
  // quotient in. A zero divisor never borrows, giving all-ones quotient and remainder A.
  assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, opnd};
  assign div_ge      = !div_diff[WIDTH];
  assign div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nxt = {acc_lo[WIDTH-2:0], div_ge};

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      portOut  <= '0;
      portHi   <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc_hi <= '0;
            if (aluop == OP_MULTU) begin
              acc_lo <= portB;
              opnd   <= portA;
            end else begin
              acc_lo <= portA;
              opnd   <= portB;
            end
            if (aluop != OP_MULTU && aluop != OP_DIVU) begin
              portOut  <= sc_res;
              portHi   <= '0;
              negative <= sc_res[WIDTH-1];
              overflow <= sc_ovf;
              zero     <= (sc_res == '0) && !sc_rsv;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          cnt    <= cnt + CNT_ONE;
          if (last_step) begin
            portOut  <= mul_lo_nxt;
            portHi   <= mul_hi_nxt;
            negative <= mul_lo_nxt[WIDTH-1];
            overflow <= 1'b0;
            zero     <= (mul_lo_nxt == '0);
          end
        end
        DIV: begin
          acc_hi <= div_rem_nxt;
          acc_lo <= div_quo_nxt;
          cnt    <= cnt + CNT_ONE;
          if (last_step) begin
            portOut  <= div_quo_nxt;
            portHi   <= div_rem_nxt;
            negative <= div_quo_nxt[WIDTH-1];
            overflow <= 1'b0;
            zero     <= (div_quo_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes the logic, shift, add/sub and compare operations in one cycle and adds iterative unsigned multiply and divide, which return a two-word result (low/quotient, high/remainder). It sits in the execute stage of either core. The stage stalls on `in_ready`/`out_valid`, so multi-cycle operations no longer force the hazard unit to special-case HI/LO.

## Interface
- WIDTH, 32, datapath width in bits; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation.
- aluop  input  4  operation code, defined under Operation.
- portA  input  WIDTH  operand A.
- portB  input  WIDTH  operand B; shifts use `portB[SHW-1:0]` as the amount.
- out_valid  output  1  result registers hold a finished result.
- out_ready  input  1  consumer takes the result.
- portOut  output  WIDTH  result, product low word, or quotient.
- portHi  output  WIDTH  product high word or remainder; 0 for single-cycle ops.
- negative  output  1  `portOut[WIDTH-1]`.
- overflow  output  1  signed overflow; ADD/SUB only, otherwise 0.
- zero  output  1  `portOut == 0`.

## Operation
- Opcodes:
  - 0 SLL: A << B[SHW-1:0].
  - 1 SRL: logical right shift.
  - 2 ADD.
  - 3 SUB.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOR.
  - 8 SLT: signed compare, result is 1 or 0.
  - 9 SLTU: unsigned compare, result is 1 or 0.
  - 10 MULTU.
  - 11 DIVU.
  - 12–15 reserved: complete as single-cycle with all outputs 0.
- Arithmetic is modulo 2^WIDTH.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
- States are IDLE, MUL, DIV and DONE.
- IDLE:
  - `in_ready = !RST`.
  - On accept (`in_valid & in_ready`), latch aluop and operands.
  - Opcodes 0–9 and 12–15 go to DONE; their result registers load on the same edge.
  - MULTU goes to MUL; DIVU goes to DIV.
- MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE. `{portHi, portOut} = A*B`, a 2·WIDTH-bit unsigned product.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then DONE. `portOut = A/B`, `portHi = A%B`, both unsigned.
- Divide by zero is not special-cased in control. It naturally yields quotient all-ones and remainder A, and the bench checks this.
- DONE:
  - `out_valid = 1`; all outputs are held stable.
  - On `out_ready`, go to IDLE. No new accept occurs in that same cycle.
- `in_ready` is 0 in MUL, DIV and DONE; inputs are ignored there.
- Flags are computed from the final `portOut`. They are registered and valid whenever `out_valid` is 1.

## Timing
- Reset values: state IDLE, `out_valid = 0`, and `portOut`, `portHi`, negative, overflow, zero all 0.
- `in_ready` is 0 while RST is high and 1 on the first cycle after RST falls.
- Reset mid-operation (MUL, DIV or DONE) aborts the operation and applies the reset values on the next edge. No `out_valid` is produced for the aborted op.
- Latency, with the accept at edge t:
  - Single-cycle ops: `out_valid` is high from cycle t+1.
  - MULTU/DIVU: `out_valid` is high from cycle t+WIDTH+1.
- Throughput:
  - With `out_ready` tied high, one single-cycle op per 2 cycles.
  - With `out_ready` tied high, one mul/div per WIDTH+2 cycles.
- Backpressure: while `out_ready = 0`, DONE holds indefinitely and outputs do not change.
- The iteration counter is SHW+1 bits. It counts WIDTH steps exactly, with no off-by-one at wrap.

## Test plan
- Reset held 3 cycles mid-DIV:
  - During reset: `out_valid = 0` and all outputs 0.
  - First cycle after release: `in_ready = 1`.
- ADD, WIDTH=32:
  - 0x7FFFFFFF + 1 gives 0x80000000 with overflow=1 and negative=1, `out_valid` at t+1.
  - SUB 5 − 5 gives 0 with zero=1 and overflow=0.
- SLT vs SLTU:
  - A = 0xFFFFFFFF, B = 1: SLT gives 1, SLTU gives 0.
  - SLL with `portB = 0x21` shifts by 1.
- MULTU:
  - 0xFFFFFFFF × 0xFFFFFFFF gives portHi = 0xFFFFFFFE and portOut = 0x00000001.
  - `out_valid` rises exactly at t+33.
- DIVU:
  - 100 / 7 gives portOut = 14 and portHi = 2.
  - 9 / 0 gives portOut = 0xFFFFFFFF and portHi = 9.
- Backpressure on MULTU:
  - Hold `out_ready = 0` for 10 cycles: outputs stay stable and `in_ready = 0`.
  - Assert `out_ready`: back in IDLE next cycle.
  - Repeat the suite with WIDTH=8.
